// File: rtl/piso_pkg.sv
// Shared types and width helpers for the parallel-in/serial-out shifter family.
package piso_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    // Counter width for a 0..n-1 range; never collapses to zero bits when n == 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_stream_if.sv
// Word-in / serial-out stream bundle between a producer and piso_stream.
interface piso_stream_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             flush;
    logic [WIDTH-1:0] din;
    logic             in_valid;
    logic             in_ready;
    logic             dout;
    logic             bit_stb;
    logic             sof;
    logic             eof;
    logic             busy;

    modport master (
        output flush, din, in_valid,
        input  in_ready, dout, bit_stb, sof, eof, busy
    );

    modport slave (
        input  flush, din, in_valid,
        output in_ready, dout, bit_stb, sof, eof, busy
    );

endinterface

// File: rtl/piso_tick_gen.sv
// Bit-period divider: tick_o marks the last clk cycle of each serial bit.
module piso_tick_gen
    import piso_pkg::*;
#(
    parameter int unsigned CLKDIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned     DivW    = cnt_width(CLKDIV);
    localparam logic [DivW-1:0] DivLast = DivW'(CLKDIV - 1);

    logic [DivW-1:0] div_cnt_d, div_cnt_q;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr_i) begin
            div_cnt_d = '0;
        end else if (en_i) begin
            div_cnt_d = (div_cnt_q == DivLast) ? '0 : div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick_o = en_i & (div_cnt_q == DivLast);

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with a one-deep holding register for gapless streaming.
module piso_stream
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LSB_FIRST  = 1,
    parameter int unsigned CLKDIV     = 1,
    parameter int unsigned IDLE_LEVEL = 1
) (
    input logic          clk,
    input logic          rst,
    piso_stream_if.slave s
);

    localparam int unsigned     BitW    = cnt_width(WIDTH);
    localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);
    localparam logic            IdleBit = 1'(IDLE_LEVEL);

    state_e           state_d, state_q;
    logic [WIDTH-1:0] shift_d, shift_q;
    logic [WIDTH-1:0] hold_d, hold_q;
    logic             hold_empty_d, hold_empty_q;
    logic [BitW-1:0]  bit_cnt_d, bit_cnt_q;
    logic             dout_d, dout_q;
    logic             bit_stb_d, bit_stb_q;
    logic             sof_d, sof_q;
    logic             eof_d, eof_q;
    logic             busy_d, busy_q;

    logic             tick;
    logic             accept;
    logic             last_bit;
    logic             load;
    logic [WIDTH-1:0] load_word;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
    endfunction

    piso_tick_gen #(
        .CLKDIV (CLKDIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (load | s.flush),
        .en_i   (state_q == StShift),
        .tick_o (tick)
    );

    always_comb begin
        accept       = s.in_valid & hold_empty_q & ~s.flush;
        last_bit     = (bit_cnt_q == BitLast);
        load         = 1'b0;
        load_word    = s.din;
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_empty_d = hold_empty_q;
        bit_cnt_d    = bit_cnt_q;
        dout_d       = dout_q;
        bit_stb_d    = 1'b0;
        sof_d        = sof_q;
        eof_d        = eof_q;
        busy_d       = busy_q;

        if (s.flush) begin
            state_d      = StIdle;
            shift_d      = '0;
            hold_d       = '0;
            hold_empty_d = 1'b1;
            bit_cnt_d    = '0;
            dout_d       = IdleBit;
            sof_d        = 1'b0;
            eof_d        = 1'b0;
            busy_d       = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) load = 1'b1;
                end
                StShift: begin
                    if (tick && last_bit) begin
                        // Word boundary: held word first, then a same-edge offer, else go idle.
                        if (!hold_empty_q) begin
                            load         = 1'b1;
                            load_word    = hold_q;
                            hold_empty_d = 1'b1;
                        end else if (accept) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                            dout_d  = IdleBit;
                            sof_d   = 1'b0;
                            eof_d   = 1'b0;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        if (tick) begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            shift_d   = shift_word(shift_q);
                            dout_d    = first_bit(shift_d);
                            bit_stb_d = 1'b1;
                            sof_d     = 1'b0;
                            eof_d     = (bit_cnt_d == BitLast);
                        end
                        if (accept) begin
                            hold_d       = s.din;
                            hold_empty_d = 1'b0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            if (load) begin
                state_d   = StShift;
                shift_d   = load_word;
                dout_d    = first_bit(load_word);
                bit_cnt_d = '0;
                bit_stb_d = 1'b1;
                sof_d     = 1'b1;
                eof_d     = 1'b0;
                busy_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_empty_q <= 1'b1;
            bit_cnt_q    <= '0;
            dout_q       <= IdleBit;
            bit_stb_q    <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_empty_q <= hold_empty_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            bit_stb_q    <= bit_stb_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            busy_q       <= busy_d;
        end
    end

    assign s.in_ready = hold_empty_q;
    assign s.dout     = dout_q;
    assign s.bit_stb  = bit_stb_q;
    assign s.sof      = sof_q;
    assign s.eof      = eof_q;
    assign s.busy     = busy_q;

endmodule
